qcw_ramp_ctrl: RTL and testbench
================================

Name: qcw_ramp_ctrl

Overview:
- Upstream sequencer for qcw_driver; sits between the interrupter/command logic and the bridge driver.
- On a fire request it latches a burst profile, pulses the driver's start input, and ramps phase_shift from a start value to an end value in timed steps.
- It then holds at the end value, halts the driver, and enforces a minimum off time before the next burst.
- Latches driver faults until software clears them.

Parameters:
STEP_DIV, 100, clk cycles per ramp/hold step (>=2)
MIN_OFF, 100000, clk cycles of enforced cooldown after every burst
STOP_TIMEOUT, 4096, max clk cycles in STOP waiting for drv_ready before declaring fault

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  master arm; deassert mid-burst forces STOP
fire  input  1  burst request, level-sampled in IDLE only
ramp_start  input  8  initial phase_shift
ramp_end  input  8  final phase_shift
ramp_step  input  8  phase_shift change per step magnitude; 0 = jump to ramp_end on first step
hold_steps  input  16  steps held at ramp_end before stop
cycle_limit_in  input  16  cycle limit forwarded to driver
clear_fault  input  1  clears latched fault
drv_ready  input  1  driver idle/ready
drv_cycle_finished  input  1  driver ended burst on its own (cycle limit)
drv_fault  input  1  driver fault
drv_start  output  1  one-cycle start pulse to driver
drv_halt  output  1  halt request to driver
phase_shift  output  8  phase shift to driver
cycle_limit  output  16  latched cycle limit to driver
busy  output  1  high in every state except IDLE
fault_latched  output  1  sticky fault flag

Behaviour:
- Reset: state IDLE; drv_start=0, drv_halt=0, phase_shift=0, cycle_limit=0, busy=0, fault_latched=0; all counters 0. Reset mid-burst returns to IDLE immediately, with no halt handshake.
- All outputs are registered.
- States: IDLE, RAMP, HOLD, STOP, COOLDOWN, FAULT.
- IDLE: if fire && enable && drv_ready && !fault_latched are sampled high in cycle N, then in cycle N+1:
  - ramp_start, ramp_end, ramp_step, hold_steps and cycle_limit_in are latched (later input changes are ignored until the next burst);
  - phase_shift=ramp_start, drv_start=1 for exactly one cycle;
  - the step counter is cleared and the state is RAMP.
  - Otherwise fire is ignored and never queued.
- Step tick: the step counter counts 0..STEP_DIV-1 and ticks on the terminal count. The first tick occurs STEP_DIV cycles after the drv_start cycle.
- RAMP: on each tick, phase_shift moves toward ramp_end by ramp_step.
  - Arithmetic is done in 9 bits and saturates at ramp_end in both directions; no wrap past 0/255.
  - Down-ramp applies when ramp_end < ramp_start.
  - If ramp_start == ramp_end, the first tick goes straight to HOLD.
  - The tick on which phase_shift equals ramp_end enters HOLD with the hold counter = 0.
- HOLD: phase_shift is constant. The hold counter increments per tick; at hold_steps ticks, go to STOP. hold_steps=0 means STOP on entry to HOLD plus one cycle.
- STOP: drv_halt=1 held. When drv_ready=1 is sampled, drv_halt drops and the state becomes COOLDOWN. If STOP_TIMEOUT cycles elapse without drv_ready, go to FAULT.
- COOLDOWN: drv_halt=0; phase_shift returns to 0 on entry. Count MIN_OFF cycles, then go to IDLE.
- drv_cycle_finished in RAMP/HOLD: go to COOLDOWN next cycle (no halt needed).
- enable=0 in RAMP/HOLD: go to STOP next cycle.
- drv_fault in RAMP/HOLD/STOP:
  - next cycle: state FAULT, fault_latched=1, drv_halt=1, phase_shift=0;
  - fault has priority over cycle_finished and enable.
- FAULT: drv_halt stays 1. clear_fault && !drv_fault leads to COOLDOWN with fault_latched=0 and drv_halt=0.
- drv_fault in IDLE or COOLDOWN does not latch a fault, but it blocks fire via drv_ready.

Test Plan (STEP_DIV=10, MIN_OFF=50, STOP_TIMEOUT=40):
1. Up-ramp: start=100, end=200, step=10, hold=3, fire at cycle N.
   - drv_start high only at N+1; phase_shift=100 at N+1.
   - 110 at N+11, reaching 200 at N+101.
   - drv_halt rises at N+131 and drops after drv_ready; busy falls 50 cycles after COOLDOWN entry.
2. Saturation and down-ramp:
   - start=250, end=255, step=10 -> 250, then 255; no wrap.
   - start=200, end=50, step=60 -> 200, 140, 80, 50.
   - step=0, start=20, end=90 -> 90 on the first tick.
3. Fault: drv_fault pulsed mid-RAMP.
   - Next cycle: FAULT, fault_latched=1, drv_halt=1, phase_shift=0.
   - fire is ignored while latched.
   - clear_fault -> COOLDOWN, flags cleared; fire is accepted again after 50 cycles.
4. Gating:
   - fire during COOLDOWN, with drv_ready=0, or with enable=0 -> no drv_start.
   - enable dropped mid-HOLD -> STOP, drv_halt held until drv_ready.
   - drv_ready held low 40 cycles in STOP -> FAULT.
5. Early finish: drv_cycle_finished pulsed during RAMP -> COOLDOWN next cycle, no drv_halt, phase_shift=0.
6. Reset mid-RAMP with phase_shift=150 -> next cycle all outputs 0, IDLE; the next fire behaves as in scenario 1.

Source files
------------

// File: rtl/qcw_ramp_ctrl.sv
//==============================================================================
// Module   : qcw_ramp_ctrl
// Purpose  : Burst sequencer ahead of the QCW bridge driver. Latches a burst
//            profile on fire, pulses drv_start, ramps phase_shift in timed
//            steps, holds, halts the driver, then enforces a cooldown.
//            Driver faults are latched until software clears them.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module qcw_ramp_ctrl #(
  parameter int STEP_DIV     = 100,
  parameter int MIN_OFF      = 100000,
  parameter int STOP_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fire,
  input  logic [7:0]  ramp_start,
  input  logic [7:0]  ramp_end,
  input  logic [7:0]  ramp_step,
  input  logic [15:0] hold_steps,
  input  logic [15:0] cycle_limit_in,
  input  logic        clear_fault,
  input  logic        drv_ready,
  input  logic        drv_cycle_finished,
  input  logic        drv_fault,
  output logic        drv_start,
  output logic        drv_halt,
  output logic [7:0]  phase_shift,
  output logic [15:0] cycle_limit,
  output logic        busy,
  output logic        fault_latched
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAMP     = 3'd1,
    S_HOLD     = 3'd2,
    S_STOP     = 3'd3,
    S_COOLDOWN = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam int SC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int T_MAX = (MIN_OFF > STOP_TIMEOUT) ? MIN_OFF : STOP_TIMEOUT;
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_DIV - 1);
  localparam logic [T_W-1:0]  OFF_LAST  = T_W'(MIN_OFF - 1);
  localparam logic [T_W-1:0]  STOP_LAST = T_W'(STOP_TIMEOUT - 1);

  state_t          state, state_nx;
  logic [SC_W-1:0] step_cnt, step_cnt_nx;
  logic [15:0]     hold_cnt, hold_cnt_nx;
  logic [T_W-1:0]  timer, timer_nx;
  logic [7:0]      end_l, end_l_nx;
  logic [7:0]      step_l, step_l_nx;
  logic [15:0]     hold_l, hold_l_nx;
  logic            down_l, down_l_nx;

  logic            drv_start_nx, drv_halt_nx, busy_nx, fault_nx;
  logic [7:0]      phase_nx;
  logic [15:0]     cycle_limit_nx;

  logic            tick;
  logic            running;
  logic [8:0]      up_sum, dn_diff;
  logic [7:0]      ramp_val;

  // Next ramp value: 9-bit arithmetic clamped at the latched end value.
  always_comb begin
    up_sum  = {1'b0, phase_shift} + {1'b0, step_l};
    dn_diff = {1'b0, phase_shift} - {1'b0, step_l};
    if (step_l == 8'd0) begin
      ramp_val = end_l;
    end else if (!down_l) begin
      ramp_val = (up_sum >= {1'b0, end_l}) ? end_l : up_sum[7:0];
    end else begin
      ramp_val = (dn_diff[8] || (dn_diff <= {1'b0, end_l})) ? end_l : dn_diff[7:0];
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_nx       = state;
    step_cnt_nx    = step_cnt;
    hold_cnt_nx    = hold_cnt;
    timer_nx       = timer;
    end_l_nx       = end_l;
    step_l_nx      = step_l;
    hold_l_nx      = hold_l;
    down_l_nx      = down_l;
    drv_start_nx   = 1'b0;
    drv_halt_nx    = drv_halt;
    phase_nx       = phase_shift;
    cycle_limit_nx = cycle_limit;
    fault_nx       = fault_latched;
    tick           = (step_cnt == STEP_LAST);
    running        = (state == S_RAMP) || (state == S_HOLD);

    case (state)
      S_IDLE: begin
        if (fire && enable && drv_ready && !fault_latched) begin
          state_nx       = S_RAMP;
          end_l_nx       = ramp_end;
          step_l_nx      = ramp_step;
          hold_l_nx      = hold_steps;
          down_l_nx      = (ramp_end < ramp_start);
          cycle_limit_nx = cycle_limit_in;
          phase_nx       = ramp_start;
          drv_start_nx   = 1'b1;
          step_cnt_nx    = '0;
        end
      end
      S_RAMP: begin
        step_cnt_nx = tick ? '0 : step_cnt + SC_W'(1);
        if (tick) begin
          phase_nx = ramp_val;
          if (ramp_val == end_l) begin
            state_nx    = S_HOLD;
            hold_cnt_nx = '0;
          end
        end
      end
      S_HOLD: begin
        step_cnt_nx = tick ? '0 : step_cnt + SC_W'(1);
        if (hold_l == 16'd0) begin
          state_nx    = S_STOP;
          drv_halt_nx = 1'b1;
          timer_nx    = '0;
        end else if (tick) begin
          if (({1'b0, hold_cnt} + 17'd1) >= {1'b0, hold_l}) begin
            state_nx    = S_STOP;
            drv_halt_nx = 1'b1;
            timer_nx    = '0;
          end else begin
            hold_cnt_nx = hold_cnt + 16'd1;
          end
        end
      end
      S_STOP: begin
        if (drv_ready) begin
          state_nx    = S_COOLDOWN;
          drv_halt_nx = 1'b0;
          phase_nx    = 8'd0;
          timer_nx    = '0;
        end else if (timer == STOP_LAST) begin
          state_nx    = S_FAULT;
          fault_nx    = 1'b1;
          drv_halt_nx = 1'b1;
          phase_nx    = 8'd0;
        end else begin
          timer_nx = timer + T_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (timer == OFF_LAST) begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + T_W'(1);
        end
      end
      S_FAULT: begin
        if (clear_fault && !drv_fault) begin
          state_nx    = S_COOLDOWN;
          fault_nx    = 1'b0;
          drv_halt_nx = 1'b0;
          timer_nx    = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Abort conditions override normal sequencing: fault first, then a
    // driver-side finish (no halt needed), then loss of enable.
    if ((running || state == S_STOP) && drv_fault) begin
      state_nx    = S_FAULT;
      fault_nx    = 1'b1;
      drv_halt_nx = 1'b1;
      phase_nx    = 8'd0;
    end else if (running && drv_cycle_finished) begin
      state_nx    = S_COOLDOWN;
      drv_halt_nx = 1'b0;
      phase_nx    = 8'd0;
      timer_nx    = '0;
    end else if (running && !enable) begin
      state_nx    = S_STOP;
      drv_halt_nx = 1'b1;
      timer_nx    = '0;
    end

    busy_nx = (state_nx != S_IDLE);
  end

  // State, counters, latched profile and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      step_cnt      <= '0;
      hold_cnt      <= '0;
      timer         <= '0;
      end_l         <= '0;
      step_l        <= '0;
      hold_l        <= '0;
      down_l        <= 1'b0;
      drv_start     <= 1'b0;
      drv_halt      <= 1'b0;
      phase_shift   <= '0;
      cycle_limit   <= '0;
      busy          <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_nx;
      step_cnt      <= step_cnt_nx;
      hold_cnt      <= hold_cnt_nx;
      timer         <= timer_nx;
      end_l         <= end_l_nx;
      step_l        <= step_l_nx;
      hold_l        <= hold_l_nx;
      down_l        <= down_l_nx;
      drv_start     <= drv_start_nx;
      drv_halt      <= drv_halt_nx;
      phase_shift   <= phase_nx;
      cycle_limit   <= cycle_limit_nx;
      busy          <= busy_nx;
      fault_latched <= fault_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qcw_ramp_ctrl.sv
//==============================================================================
// Module   : tb_qcw_ramp_ctrl
// Purpose  : Directed self-checking bench for qcw_ramp_ctrl
//            (STEP_DIV=10, MIN_OFF=50, STOP_TIMEOUT=40).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_qcw_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        fire = 1'b0;
  logic [7:0]  ramp_start = '0;
  logic [7:0]  ramp_end = '0;
  logic [7:0]  ramp_step = '0;
  logic [15:0] hold_steps = '0;
  logic [15:0] cycle_limit_in = '0;
  logic        clear_fault = 1'b0;
  logic        drv_ready = 1'b1;
  logic        drv_cycle_finished = 1'b0;
  logic        drv_fault = 1'b0;
  logic        drv_start, drv_halt, busy, fault_latched;
  logic [7:0]  phase_shift;
  logic [15:0] cycle_limit;

  int n_cmp = 0;
  int n_err = 0;

  qcw_ramp_ctrl #(.STEP_DIV(10), .MIN_OFF(50), .STOP_TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fire(fire),
    .ramp_start(ramp_start), .ramp_end(ramp_end), .ramp_step(ramp_step),
    .hold_steps(hold_steps), .cycle_limit_in(cycle_limit_in),
    .clear_fault(clear_fault), .drv_ready(drv_ready),
    .drv_cycle_finished(drv_cycle_finished), .drv_fault(drv_fault),
    .drv_start(drv_start), .drv_halt(drv_halt), .phase_shift(phase_shift),
    .cycle_limit(cycle_limit), .busy(busy), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a profile and fire for one cycle; returns observing cycle N+1.
  task automatic fire_burst(input logic [7:0] s, input logic [7:0] e,
                            input logic [7:0] st, input logic [15:0] h,
                            input logic [15:0] cl);
    ramp_start = s; ramp_end = e; ramp_step = st; hold_steps = h;
    cycle_limit_in = cl; fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  // Step until busy drops (bounded); reports the number of steps taken.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_cmp++; if ({drv_start, drv_halt, phase_shift, cycle_limit, busy, fault_latched} !== 28'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", {drv_start, drv_halt, phase_shift, cycle_limit, busy, fault_latched}); end
    rst = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_up_ramp();
    int c;
    fire_burst(8'd100, 8'd200, 8'd10, 16'd3, 16'h1234);
    drv_ready = 1'b0;
    ramp_start = 8'd7; ramp_end = 8'd9; ramp_step = 8'd1; hold_steps = 16'd99; cycle_limit_in = 16'h0;
    n_cmp++; if (drv_start !== 1'b1) begin n_err++; $display("FAIL up_start_pulse: got %b want 1", drv_start); end
    n_cmp++; if (phase_shift !== 8'd100) begin n_err++; $display("FAIL up_phase_n1: got %0d want 100", phase_shift); end
    n_cmp++; if (cycle_limit !== 16'h1234) begin n_err++; $display("FAIL up_cycle_limit: got %h want 1234", cycle_limit); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL up_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (drv_start !== 1'b0) begin n_err++; $display("FAIL up_start_once: got %b want 0", drv_start); end
    repeat (9) step();
    n_cmp++; if (phase_shift !== 8'd110) begin n_err++; $display("FAIL up_phase_n11: got %0d want 110", phase_shift); end
    repeat (89) step();
    n_cmp++; if (phase_shift !== 8'd190) begin n_err++; $display("FAIL up_phase_n100: got %0d want 190", phase_shift); end
    step();
    n_cmp++; if (phase_shift !== 8'd200) begin n_err++; $display("FAIL up_phase_n101: got %0d want 200", phase_shift); end
    repeat (29) step();
    n_cmp++; if (drv_halt !== 1'b0) begin n_err++; $display("FAIL up_halt_n130: got %b want 0", drv_halt); end
    step();
    n_cmp++; if (drv_halt !== 1'b1) begin n_err++; $display("FAIL up_halt_n131: got %b want 1", drv_halt); end
    repeat (4) step();
    n_cmp++; if (drv_halt !== 1'b1) begin n_err++; $display("FAIL up_halt_held: got %b want 1", drv_halt); end
    drv_ready = 1'b1;
    step();
    n_cmp++; if ({drv_halt, phase_shift, busy} !== {1'b0, 8'd0, 1'b1}) begin n_err++; $display("FAIL up_cooldown_entry: got halt=%b ph=%0d busy=%b want 0/0/1", drv_halt, phase_shift, busy); end
    wait_idle(c);
    n_cmp++; if (c !== 50) begin n_err++; $display("FAIL up_cooldown_len: got %0d want 50", c); end
  endtask

  task automatic test_saturation();
    int c;
    logic [7:0] dn_exp [3] = '{8'd140, 8'd80, 8'd50};
    fire_burst(8'd250, 8'd255, 8'd10, 16'd0, 16'd5);
    n_cmp++; if (phase_shift !== 8'd250) begin n_err++; $display("FAIL sat_phase_start: got %0d want 250", phase_shift); end
    repeat (10) step();
    n_cmp++; if (phase_shift !== 8'd255) begin n_err++; $display("FAIL sat_phase_clamp: got %0d want 255", phase_shift); end
    step();
    n_cmp++; if (drv_halt !== 1'b1) begin n_err++; $display("FAIL sat_hold0_stop: got %b want 1", drv_halt); end
    wait_idle(c);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_idle: got %b want 0", busy); end

    fire_burst(8'd200, 8'd50, 8'd60, 16'd0, 16'd5);
    n_cmp++; if (phase_shift !== 8'd200) begin n_err++; $display("FAIL down_phase_start: got %0d want 200", phase_shift); end
    for (int k = 0; k < 3; k++) begin
      repeat (10) step();
      n_cmp++; if (phase_shift !== dn_exp[k]) begin n_err++; $display("FAIL down_phase_%0d: got %0d want %0d", k, phase_shift, dn_exp[k]); end
    end
    wait_idle(c);

    fire_burst(8'd20, 8'd90, 8'd0, 16'd0, 16'd5);
    n_cmp++; if (phase_shift !== 8'd20) begin n_err++; $display("FAIL jump_phase_start: got %0d want 20", phase_shift); end
    repeat (9) step();
    n_cmp++; if (phase_shift !== 8'd20) begin n_err++; $display("FAIL jump_phase_pre: got %0d want 20", phase_shift); end
    step();
    n_cmp++; if (phase_shift !== 8'd90) begin n_err++; $display("FAIL jump_phase_tick: got %0d want 90", phase_shift); end
    wait_idle(c);
  endtask

  task automatic test_fault();
    int c;
    fire_burst(8'd100, 8'd200, 8'd10, 16'd5, 16'd7);
    repeat (15) step();
    drv_fault = 1'b1;
    step();
    drv_fault = 1'b0;
    n_cmp++; if ({fault_latched, drv_halt, phase_shift, busy} !== {1'b1, 1'b1, 8'd0, 1'b1}) begin n_err++; $display("FAIL fault_entry: got lat=%b halt=%b ph=%0d busy=%b want 1/1/0/1", fault_latched, drv_halt, phase_shift, busy); end
    fire = 1'b1;
    repeat (3) step();
    fire = 1'b0;
    n_cmp++; if ({drv_start, fault_latched, drv_halt} !== 3'b011) begin n_err++; $display("FAIL fault_fire_ignored: got %b want 011", {drv_start, fault_latched, drv_halt}); end
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    n_cmp++; if ({fault_latched, drv_halt, busy} !== 3'b001) begin n_err++; $display("FAIL fault_clear: got %b want 001", {fault_latched, drv_halt, busy}); end
    fire = 1'b1;
    step();
    fire = 1'b0;
    n_cmp++; if (drv_start !== 1'b0) begin n_err++; $display("FAIL cooldown_fire_ignored: got %b want 0", drv_start); end
    wait_idle(c);
    n_cmp++; if (c !== 49) begin n_err++; $display("FAIL fault_cooldown_len: got %0d want 49", c); end
    fire_burst(8'd10, 8'd20, 8'd1, 16'd1, 16'd7);
    n_cmp++; if (drv_start !== 1'b1) begin n_err++; $display("FAIL fault_refire: got %b want 1", drv_start); end
    drv_cycle_finished = 1'b1;
    step();
    drv_cycle_finished = 1'b0;
    wait_idle(c);
  endtask

  task automatic test_gating();
    int c;
    drv_ready = 1'b0; fire = 1'b1;
    step();
    n_cmp++; if ({drv_start, busy} !== 2'b00) begin n_err++; $display("FAIL gate_not_ready: got %b want 00", {drv_start, busy}); end
    drv_ready = 1'b1; enable = 1'b0;
    step();
    n_cmp++; if ({drv_start, busy} !== 2'b00) begin n_err++; $display("FAIL gate_disabled: got %b want 00", {drv_start, busy}); end
    fire = 1'b0; enable = 1'b1;

    fire_burst(8'd10, 8'd20, 8'd10, 16'd20, 16'd7);
    repeat (10) step();
    n_cmp++; if (phase_shift !== 8'd20) begin n_err++; $display("FAIL gate_hold_phase: got %0d want 20", phase_shift); end
    repeat (5) step();
    enable = 1'b0; drv_ready = 1'b0;
    step();
    enable = 1'b1;
    n_cmp++; if (drv_halt !== 1'b1) begin n_err++; $display("FAIL gate_enable_stop: got %b want 1", drv_halt); end
    repeat (5) step();
    n_cmp++; if ({drv_halt, busy} !== 2'b11) begin n_err++; $display("FAIL gate_stop_held: got %b want 11", {drv_halt, busy}); end
    drv_ready = 1'b1;
    step();
    n_cmp++; if ({drv_halt, busy} !== 2'b01) begin n_err++; $display("FAIL gate_stop_release: got %b want 01", {drv_halt, busy}); end
    wait_idle(c);
    n_cmp++; if (c !== 50) begin n_err++; $display("FAIL gate_cooldown_len: got %0d want 50", c); end

    fire_burst(8'd30, 8'd30, 8'd5, 16'd0, 16'd7);
    drv_ready = 1'b0;
    repeat (50) step();
    n_cmp++; if ({drv_halt, fault_latched} !== 2'b10) begin n_err++; $display("FAIL timeout_pre: got %b want 10", {drv_halt, fault_latched}); end
    step();
    n_cmp++; if ({drv_halt, fault_latched} !== 2'b11) begin n_err++; $display("FAIL timeout_fault: got %b want 11", {drv_halt, fault_latched}); end
    drv_ready = 1'b1; clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    wait_idle(c);
  endtask

  task automatic test_early_finish();
    int c;
    fire_burst(8'd100, 8'd200, 8'd10, 16'd3, 16'd7);
    repeat (12) step();
    n_cmp++; if (phase_shift !== 8'd110) begin n_err++; $display("FAIL early_phase: got %0d want 110", phase_shift); end
    drv_cycle_finished = 1'b1;
    step();
    drv_cycle_finished = 1'b0;
    n_cmp++; if ({drv_halt, phase_shift, busy} !== {1'b0, 8'd0, 1'b1}) begin n_err++; $display("FAIL early_cooldown: got halt=%b ph=%0d busy=%b want 0/0/1", drv_halt, phase_shift, busy); end
    wait_idle(c);
    n_cmp++; if (c !== 50) begin n_err++; $display("FAIL early_cooldown_len: got %0d want 50", c); end
  endtask

  task automatic test_reset_mid();
    int c;
    fire_burst(8'd100, 8'd200, 8'd10, 16'd3, 16'h55);
    repeat (50) step();
    n_cmp++; if (phase_shift !== 8'd150) begin n_err++; $display("FAIL rmid_phase: got %0d want 150", phase_shift); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({drv_start, drv_halt, phase_shift, cycle_limit, busy, fault_latched} !== 28'd0) begin n_err++; $display("FAIL rmid_outputs: got %h want 0", {drv_start, drv_halt, phase_shift, cycle_limit, busy, fault_latched}); end
    fire_burst(8'd100, 8'd200, 8'd10, 16'd3, 16'h66);
    n_cmp++; if ({drv_start, phase_shift} !== {1'b1, 8'd100}) begin n_err++; $display("FAIL rmid_refire: got st=%b ph=%0d want 1/100", drv_start, phase_shift); end
    repeat (10) step();
    n_cmp++; if (phase_shift !== 8'd110) begin n_err++; $display("FAIL rmid_first_tick: got %0d want 110", phase_shift); end
    drv_cycle_finished = 1'b1;
    step();
    drv_cycle_finished = 1'b0;
    wait_idle(c);
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_saturation();
    test_fault();
    test_gating();
    test_early_finish();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
